riscv_mmio_gpio: RTL and testbench
==================================

RISCV_MMIO_GPIO -- requirements
Module: riscv_mmio_gpio

Interface
REQ-001 SHALL have parameter XLEN, default 32, bus data/address width.
REQ-002 SHALL have parameter N_OUT, default 8, output channel count (1..XLEN).
REQ-003 SHALL have parameter N_IN, default 8, input channel count (1..XLEN).
REQ-004 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (>=2).
REQ-005 SHALL have parameter DEBOUNCE, default 0, cycles an input must hold a new level before acceptance; 0 disables debounce.
REQ-006 SHALL use one clock; reset is synchronous and active-high. Ports: i_clk, i_rst.
REQ-007 i_clk  input  1  clock; all state updates on rising edge.
REQ-008 i_rst  input  1  synchronous active-high reset.
REQ-009 i_sel  input  1  peripheral selected for the current access.
REQ-010 i_addr  input  XLEN  byte address; only bits [4:2] decoded.
REQ-011 i_wr_en  input  1  write strobe, qualified by i_sel.
REQ-012 i_wr_data  input  XLEN  write data.
REQ-013 o_rd_data  output  XLEN  combinational read data.
REQ-014 i_in  input  N_IN  asynchronous input pins (switches).
REQ-015 o_out  output  N_OUT  registered output pins (LEDs).
REQ-016 o_irq  output  1  level interrupt request.

Function
REQ-017 Register map by i_addr[4:2]: 0 OUT (RW), 1 IN (RO), 2 EDGE (RW1C), 3 IRQ_EN (RW), 4 OUT_SET (WO), 5 OUT_CLR (WO); 6-7 reserved.
REQ-018 Write occurs only when i_sel & i_wr_en at the rising edge; the written value appears on o_out/registers the next cycle.
REQ-019 OUT write: OUT <= i_wr_data[N_OUT-1:0]; OUT_SET: OUT <= OUT | data; OUT_CLR: OUT <= OUT & ~data.
REQ-020 o_out SHALL equal OUT directly (no logic after the register).
REQ-021 i_in SHALL pass through a SYNC_STAGES-deep flop chain per bit before any other use.
REQ-022 DEBOUNCE=0: stable value IN <= synchronised value every cycle; i_in change visible in IN after SYNC_STAGES+1 edges.
REQ-023 DEBOUNCE>0: per-bit counter increments while synchronised bit != IN bit, clears when equal; IN bit takes the new level on the edge the counter reaches DEBOUNCE, counter clears then.
REQ-024 Glitch shorter than DEBOUNCE cycles (post-sync) SHALL never change IN.
REQ-025 EDGE bit SHALL set on the same edge its IN bit transitions 0->1; falling edges ignored.
REQ-026 EDGE write: bits with data=1 clear, data=0 unchanged; a set and a clear of the same bit in one cycle -> set wins.
REQ-027 o_irq SHALL equal |(EDGE & IRQ_EN), combinational from registers.
REQ-028 Reads: zero-extended to XLEN; OUT/IN/EDGE/IRQ_EN return register value; OUT_SET, OUT_CLR, reserved read 0.
REQ-029 Writes to IN and reserved offsets SHALL be ignored; writes with i_sel=0 ignored; bits above channel width ignored.
REQ-030 o_rd_data SHALL be 0 when i_sel=0.

Reset
REQ-031 On i_rst at a rising edge: OUT, EDGE, IRQ_EN, IN, all sync flops, all debounce counters <= 0; o_out=0, o_irq=0 next cycle.
REQ-032 Reset SHALL override any simultaneous write or edge event.
REQ-033 Input held high through reset SHALL produce one EDGE set after release, once it propagates per REQ-022/023.

Verification
REQ-034 Reset, write OUT=0xA5 at offset 0x0 -> o_out=0xA5 next cycle; read 0x0 returns 0x000000A5.
REQ-035 OUT=0xF0, OUT_SET 0x0F then OUT_CLR 0x81 -> o_out 0xFF then 0x7E; reads of 0x10/0x14 return 0.
REQ-036 DEBOUNCE=0, i_in 0x00->0x04 -> IN=0x04 after 3 edges, EDGE=0x04; IRQ_EN=0x04 -> o_irq=1; write EDGE 0x04 -> o_irq=0 next cycle.
REQ-037 DEBOUNCE=4, bit0 pulse of 3 post-sync cycles -> IN stays 0, EDGE stays 0; 5-cycle pulse -> IN bit0=1, EDGE bit0=1.
REQ-038 W1C of EDGE bit1 on same edge bit1 rises -> EDGE bit1 remains 1.
REQ-039 i_rst asserted mid-debounce with OUT=0xFF, IRQ_EN=0xFF -> all registers 0, o_irq=0 next cycle; i_sel=0 write ignored.

Source files
------------

// File: rtl/riscv_mmio_gpio.sv
// riscv_mmio_gpio: memory-mapped GPIO with synchronised, optionally debounced inputs and rising-edge interrupts
module riscv_mmio_gpio #(
    parameter int XLEN        = 32,
    parameter int N_OUT       = 8,
    parameter int N_IN        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sel,
    input  logic [XLEN-1:0]   i_addr,
    input  logic              i_wr_en,
    input  logic [XLEN-1:0]   i_wr_data,
    output logic [XLEN-1:0]   o_rd_data,
    input  logic [N_IN-1:0]   i_in,
    output logic [N_OUT-1:0]  o_out,
    output logic              o_irq
);
    localparam logic [2:0] A_OUT = 3'd0, A_IN = 3'd1, A_EDGE = 3'd2, A_IRQ_EN = 3'd3, A_SET = 3'd4, A_CLR = 3'd5;
    logic [SYNC_STAGES-1:0][N_IN-1:0] sync_q, sync_d;
    logic [N_IN-1:0] sync_s, in_q, in_d, edge_q, edge_d, irq_en_q, irq_en_d, wd_in;
    logic [N_OUT-1:0] out_q, out_d, wd_out;
    logic [2:0] off;
    logic we;
    logic unused_ok;
    assign unused_ok = ^{i_addr, i_wr_data};
    assign sync_d = {sync_q[SYNC_STAGES-2:0], i_in};
    assign sync_s = sync_q[SYNC_STAGES-1];
    generate
        if (DEBOUNCE == 0) begin : g_nodb
            assign in_d = sync_s;
        end else begin : g_db
            localparam int CW = $clog2(DEBOUNCE + 1);
            logic [N_IN-1:0][CW-1:0] cnt_q, cnt_d;
            // a bit must disagree with IN for DEBOUNCE consecutive cycles before it is accepted
            always_comb begin
                in_d  = in_q;
                cnt_d = '0;
                for (int i = 0; i < N_IN; i++) begin
                    if (sync_s[i] != in_q[i]) begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                        if (cnt_d[i] == CW'(DEBOUNCE)) begin
                            in_d[i]  = sync_s[i];
                            cnt_d[i] = '0;
                        end
                    end
                end
            end
            always_ff @(posedge i_clk) begin
                if (i_rst) cnt_q <= '0;
                else       cnt_q <= cnt_d;
            end
        end
    endgenerate
    always_comb begin
        we       = i_sel & i_wr_en;
        off      = i_addr[4:2];
        wd_out   = i_wr_data[N_OUT-1:0];
        wd_in    = i_wr_data[N_IN-1:0];
        out_d    = !we              ? out_q :
                   off == A_OUT     ? wd_out :
                   off == A_SET     ? out_q | wd_out :
                   off == A_CLR     ? out_q & ~wd_out : out_q;
        irq_en_d = (we && off == A_IRQ_EN) ? wd_in : irq_en_q;
        edge_d   = (edge_q & ~((we && off == A_EDGE) ? wd_in : '0)) | (in_d & ~in_q);
        o_rd_data = !i_sel           ? '0 :
                    off == A_OUT     ? XLEN'(out_q) :
                    off == A_IN      ? XLEN'(in_q) :
                    off == A_EDGE    ? XLEN'(edge_q) :
                    off == A_IRQ_EN  ? XLEN'(irq_en_q) : '0;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q   <= '0;
            in_q     <= '0;
            edge_q   <= '0;
            irq_en_q <= '0;
            out_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            in_q     <= in_d;
            edge_q   <= edge_d;
            irq_en_q <= irq_en_d;
            out_q    <= out_d;
        end
    end
    assign o_out = out_q;
    assign o_irq = |(edge_q & irq_en_q);
endmodule

// File: tb/tb_riscv_mmio_gpio.sv
// tb_riscv_mmio_gpio: directed checks of the GPIO with and without input debounce
module tb_riscv_mmio_gpio;
    logic clk = 1'b0;
    logic rst, sel, wr_en, irq0, irq4;
    logic [31:0] addr, wdata, rd0, rd4, r0, r4;
    logic [7:0] in0, in4, out0, out4;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    riscv_mmio_gpio dut0 (
        .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_addr(addr), .i_wr_en(wr_en),
        .i_wr_data(wdata), .o_rd_data(rd0), .i_in(in0), .o_out(out0), .o_irq(irq0)
    );
    riscv_mmio_gpio #(.DEBOUNCE(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_addr(addr), .i_wr_en(wr_en),
        .i_wr_data(wdata), .o_rd_data(rd4), .i_in(in4), .o_out(out4), .o_irq(irq4)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        sel = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; wr_en = 1'b0;
    endtask
    task automatic rd(input logic [31:0] a);
        sel = 1'b1; wr_en = 1'b0; addr = a;
        #1;
        r0 = rd0; r4 = rd4;
        sel = 1'b0;
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        rst = 1'b1; sel = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0; in0 = '0; in4 = '0;
        cyc(2);
        rst = 1'b0;
        chk("rst_out", 32'(out0), 32'h0);
        chk("rst_irq", 32'(irq0), 32'h0);
        rd(32'h0); chk("rst_rd_out", r0, 32'h0);
        wr(32'h0, 32'hA5);
        chk("out_a5", 32'(out0), 32'hA5);
        rd(32'h0); chk("rd_out_a5", r0, 32'h0000_00A5); chk("rd_out_a5_db", r4, 32'h0000_00A5);
        wr(32'h0, 32'hF0);
        wr(32'h10, 32'h0F); chk("out_set", 32'(out0), 32'hFF);
        wr(32'h14, 32'h81); chk("out_clr", 32'(out0), 32'h7E);
        rd(32'h10); chk("rd_set_zero", r0, 32'h0);
        rd(32'h14); chk("rd_clr_zero", r0, 32'h0);
        rd(32'h1C); chk("rd_rsvd_zero", r0, 32'h0);
        wr(32'h18, 32'hFF);
        wr(32'h04, 32'hFF);
        chk("rsvd_in_wr_ignored", 32'(out0), 32'h7E);
        rd(32'h04); chk("in_wr_ignored", r0, 32'h0);
        wr(32'h20, 32'hFFFF_FF3C); chk("addr_alias_width", 32'(out0), 32'h3C);
        sel = 1'b0; wr_en = 1'b1; addr = 32'h0; wdata = 32'h0;
        #1 chk("rd_nosel", rd0, 32'h0);
        cyc(1);
        wr_en = 1'b0;
        chk("nosel_wr_ignored", 32'(out0), 32'h3C);
        in0 = 8'h04;
        cyc(2);
        rd(32'h04); chk("in_after_2", r0, 32'h0);
        cyc(1);
        rd(32'h04); chk("in_after_3", r0, 32'h04);
        rd(32'h08); chk("edge_rise", r0, 32'h04);
        chk("irq_masked", 32'(irq0), 32'h0);
        wr(32'h0C, 32'h04); chk("irq_on", 32'(irq0), 32'h1);
        wr(32'h08, 32'h04); chk("irq_w1c", 32'(irq0), 32'h0);
        rd(32'h08); chk("edge_cleared", r0, 32'h0);
        in0 = 8'h00;
        cyc(4);
        rd(32'h04); chk("in_fall", r0, 32'h0);
        rd(32'h08); chk("edge_fall_ignored", r0, 32'h0);
        in4 = 8'h01;
        cyc(3);
        in4 = 8'h00;
        cyc(10);
        rd(32'h04); chk("db_glitch_in", r4, 32'h0);
        rd(32'h08); chk("db_glitch_edge", r4, 32'h0);
        in4 = 8'h01;
        cyc(5);
        in4 = 8'h00;
        cyc(1);
        rd(32'h04); chk("db_pulse_in", r4, 32'h01);
        rd(32'h08); chk("db_pulse_edge", r4, 32'h01);
        cyc(8);
        rd(32'h04); chk("db_release_in", r4, 32'h0);
        rd(32'h08); chk("db_edge_sticky", r4, 32'h01);
        wr(32'h08, 32'hFF);
        in0 = 8'h02;
        cyc(2);
        sel = 1'b1; wr_en = 1'b1; addr = 32'h08; wdata = 32'h02;
        cyc(1);
        sel = 1'b0; wr_en = 1'b0;
        rd(32'h08); chk("set_wins", r0, 32'h02);
        wr(32'h08, 32'h02);
        rd(32'h08); chk("edge_w1c_bit1", r0, 32'h0);
        wr(32'h0, 32'hFF);
        wr(32'h0C, 32'hFF);
        in4 = 8'h02;
        cyc(8);
        chk("irq4_pre_rst", 32'(irq4), 32'h1);
        in4 = 8'h06;
        cyc(3);
        rst = 1'b1; sel = 1'b1; wr_en = 1'b1; addr = 32'h0; wdata = 32'h55;
        cyc(1);
        rst = 1'b0; sel = 1'b0; wr_en = 1'b0;
        chk("rst_mid_out0", 32'(out0), 32'h0);
        chk("rst_mid_out4", 32'(out4), 32'h0);
        chk("rst_mid_irq4", 32'(irq4), 32'h0);
        rd(32'h0);  chk("rst_mid_rd_out", r4, 32'h0);
        rd(32'h04); chk("rst_mid_rd_in", r4, 32'h0);
        rd(32'h08); chk("rst_mid_rd_edge0", r0, 32'h0); chk("rst_mid_rd_edge4", r4, 32'h0);
        rd(32'h0C); chk("rst_mid_rd_irqen", r4, 32'h0);
        cyc(12);
        rd(32'h08); chk("held_edge0", r0, 32'h02); chk("held_edge4", r4, 32'h06);
        rd(32'h04); chk("held_in4", r4, 32'h06);
        chk("irq_after_rst", 32'(irq4), 32'h0);
        sel = 1'b0; wr_en = 1'b1; addr = 32'h0; wdata = 32'hAA;
        cyc(1);
        wr_en = 1'b0;
        chk("nosel_after_rst", 32'(out0), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
